// File: rtl/wishbone_sram_banked_if.sv
// Wishbone classic bus bundle between the Caravel management core and the
// banked SRAM slave.
interface wishbone_sram_banked_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wishbone_sram_banked.sv
// Wishbone classic slave fronting NUM_BANKS single-port SRAM macros.
// One bank is selected per access; macro read latency is a parameter and
// every output, including the macro controls, comes straight from a flop.
module wishbone_sram_banked #(
    parameter int          NUM_BANKS    = 2,
    parameter int          BANK_ADDR_W  = 8,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK    = 32'hFFFF_0000
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    wishbone_sram_banked_if.slave     wbs,
    output logic [NUM_BANKS-1:0]      sram_csb_o,
    output logic [NUM_BANKS-1:0]      sram_web_o,
    output logic [3:0]                sram_wmask_o,
    output logic [BANK_ADDR_W-1:0]    sram_addr_o,
    output logic [31:0]               sram_din_o,
    input  logic [32*NUM_BANKS-1:0]   sram_dout_i,
    output logic [NUM_BANKS-1:0]      bank_active_o,
    output logic                      busy_o
);
    localparam int BANK_SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W      = 2;
    localparam logic [BANK_SEL_W:0] NB_L = (BANK_SEL_W + 1)'(NUM_BANKS);
    // Word and bank fields together; they must sit below the decoded window.
    localparam logic [63:0] FIELD_MASK = ((64'd1 << (BANK_ADDR_W + BANK_SEL_W)) - 64'd1) << 2;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("READ_LATENCY must be within 1..4");
    end
    if (NUM_BANKS < 1 || NUM_BANKS > 8) begin : g_bad_banks
        $error("NUM_BANKS must be within 1..8");
    end
    if ((FIELD_MASK & {32'h0, ADDR_MASK}) != 64'd0) begin : g_bad_mask
        $error("bank/word address fields overlap ADDR_MASK");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    typedef struct packed {
        logic                  we;
        logic [BANK_SEL_W-1:0] bank;
    } req_t;

    state_t                 state_q, state_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    req_t                   req_q, req_n;
    logic                   ack_q, ack_n;
    logic [31:0]            dat_q, dat_n;
    logic [NUM_BANKS-1:0]   csb_q, csb_n;
    logic [NUM_BANKS-1:0]   web_q, web_n;
    logic [3:0]             wmask_q, wmask_n;
    logic [BANK_ADDR_W-1:0] addr_q, addr_n;
    logic [31:0]            din_q, din_n;
    logic [NUM_BANKS-1:0]   act_q, act_n;
    logic                   busy_q, busy_n;

    logic                   hit;
    logic [BANK_ADDR_W-1:0] word;
    logic [BANK_SEL_W-1:0]  bank;
    logic                   bank_ok;
    logic [NUM_BANKS-1:0]   bank_oh;
    logic [31:0]            rd_slice;

    // Upper address bits between the bank field and the mask alias freely.
    assign hit     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ((wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign word    = wbs.wbs_adr_i[BANK_ADDR_W+1:2];
    assign bank    = wbs.wbs_adr_i[BANK_ADDR_W+2 +: BANK_SEL_W];
    assign bank_ok = {1'b0, bank} < NB_L;

    // Decode the requested bank one-hot and pick the captured bank's read slice.
    always_comb begin
        bank_oh  = '0;
        rd_slice = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            bank_oh[k] = (bank == BANK_SEL_W'(k));
            if (req_q.bank == BANK_SEL_W'(k)) rd_slice = sram_dout_i[k*32 +: 32];
        end
    end

    // Next-state and next-output logic; everything defaults to holding.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        req_n   = req_q;
        ack_n   = 1'b0;
        dat_n   = dat_q;
        csb_n   = '1;
        web_n   = '1;
        wmask_n = wmask_q;
        addr_n  = addr_q;
        din_n   = din_q;
        act_n   = act_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    addr_n  = word;
                    din_n   = wbs.wbs_dat_i;
                    wmask_n = wbs.wbs_we_i ? wbs.wbs_sel_i : 4'h0;
                    req_n   = '{we: wbs.wbs_we_i, bank: bank};
                    if (bank_ok) begin
                        csb_n   = ~bank_oh;
                        web_n   = wbs.wbs_we_i ? ~bank_oh : '1;
                        act_n   = bank_oh;
                        state_n = ACCESS;
                    end else begin
                        // Hole in the bank space: acknowledge without touching a macro.
                        ack_n   = 1'b1;
                        if (!wbs.wbs_we_i) dat_n = '0;
                        state_n = ACK;
                    end
                end
            end
            ACCESS: begin
                if (!wbs.wbs_cyc_i) begin
                    act_n   = '0;
                    state_n = IDLE;
                end else if (req_q.we) begin
                    ack_n   = 1'b1;
                    state_n = ACK;
                end else begin
                    cnt_n   = CNT_W'(READ_LATENCY - 1);
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (!wbs.wbs_cyc_i) begin
                    act_n   = '0;
                    state_n = IDLE;
                end else if (cnt_q == '0) begin
                    dat_n   = rd_slice;
                    ack_n   = 1'b1;
                    state_n = ACK;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            ACK: begin
                act_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            csb_q   <= '1;
            web_q   <= '1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            act_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            req_q   <= req_n;
            ack_q   <= ack_n;
            dat_q   <= dat_n;
            csb_q   <= csb_n;
            web_q   <= web_n;
            wmask_q <= wmask_n;
            addr_q  <= addr_n;
            din_q   <= din_n;
            act_q   <= act_n;
            busy_q  <= busy_n;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign sram_csb_o    = csb_q;
    assign sram_web_o    = web_q;
    assign sram_wmask_o  = wmask_q;
    assign sram_addr_o   = addr_q;
    assign sram_din_o    = din_q;
    assign bank_active_o = act_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_wishbone_sram_banked.sv
// Bench for wishbone_sram_banked: four builds side by side (RL 1..4; the
// first with two banks, the others with three) each with its own macro models.
module tb_wishbone_sram_banked;
    logic clk;
    logic [3:0]        rst, cyc, stb, we, ack, busy;
    logic [3:0][3:0]   sel, csb, web, act, wmask;
    logic [3:0][31:0]  adr, dati, dato, din;
    logic [3:0][7:0]   addr;

    int total = 0;
    int bad   = 0;

    // Reference memory contents per build / bank / word.
    logic [31:0] refm [4][4][256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NB = (g == 0) ? 2 : 3;
        localparam int RL = g + 1;
        wishbone_sram_banked_if bus();
        logic [NB-1:0]    csb_w, web_w, act_w;
        logic [3:0]       wmask_w;
        logic [7:0]       addr_w;
        logic [31:0]      din_w;
        logic [32*NB-1:0] dout_w;
        logic [31:0]      mem     [NB][256];
        logic [31:0]      rd_pipe [NB][4];

        assign bus.wbs_cyc_i = cyc[g];
        assign bus.wbs_stb_i = stb[g];
        assign bus.wbs_we_i  = we[g];
        assign bus.wbs_sel_i = sel[g];
        assign bus.wbs_adr_i = adr[g];
        assign bus.wbs_dat_i = dati[g];
        assign ack[g]   = bus.wbs_ack_o;
        assign dato[g]  = bus.wbs_dat_o;
        assign csb[g]   = {{(4-NB){1'b1}}, csb_w};
        assign web[g]   = {{(4-NB){1'b1}}, web_w};
        assign act[g]   = {{(4-NB){1'b0}}, act_w};
        assign wmask[g] = wmask_w;
        assign addr[g]  = addr_w;
        assign din[g]   = din_w;

        wishbone_sram_banked #(.NUM_BANKS(NB), .READ_LATENCY(RL)) u_dut (
            .wb_clk_i     (clk),
            .wb_rst_i     (rst[g]),
            .wbs          (bus),
            .sram_csb_o   (csb_w),
            .sram_web_o   (web_w),
            .sram_wmask_o (wmask_w),
            .sram_addr_o  (addr_w),
            .sram_din_o   (din_w),
            .sram_dout_i  (dout_w),
            .bank_active_o(act_w),
            .busy_o       (busy[g])
        );

        initial begin
            for (int k = 0; k < NB; k++)
                for (int w = 0; w < 256; w++) mem[k][w] = 32'h0;
        end

        // Macro model: read data appears RL cycles after the select edge;
        // unselected cycles push junk so an early capture shows up.
        always @(posedge clk) begin
            for (int k = 0; k < NB; k++) begin
                for (int i = 1; i < 4; i++) rd_pipe[k][i] <= rd_pipe[k][i-1];
                rd_pipe[k][0] <= 32'hBAD0_0000 | k;
                if (!csb_w[k]) begin
                    if (!web_w[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (wmask_w[b]) mem[k][addr_w][b*8 +: 8] <= din_w[b*8 +: 8];
                    end else begin
                        rd_pipe[k][0] <= mem[k][addr_w];
                    end
                end
            end
        end

        for (genvar h = 0; h < NB; h++) begin : g_dout
            assign dout_w[h*32 +: 32] = rd_pipe[h][RL-1];
        end
    end

    function automatic int nb_of(int d);  return (d == 0) ? 2 : 3; endfunction
    function automatic int rl_of(int d);  return d + 1;            endfunction
    function automatic int bsw_of(int d); return (d == 0) ? 1 : 2; endfunction

    function automatic int bank_of(int d, logic [31:0] a);
        return int'((a >> 10) & ((32'd1 << bsw_of(d)) - 1));
    endfunction

    function automatic int word_of(logic [31:0] a);
        return int'((a >> 2) & 32'hFF);
    endfunction

    function automatic void ref_write(int d, logic [31:0] a, logic [31:0] data, logic [3:0] s);
        int bk, wd;
        bk = bank_of(d, a);
        wd = word_of(a);
        if (bk < nb_of(d))
            for (int b = 0; b < 4; b++)
                if (s[b]) refm[d][bk][wd][b*8 +: 8] = data[b*8 +: 8];
    endfunction

    function automatic logic [31:0] ref_read(int d, logic [31:0] a);
        if (bank_of(d, a) >= nb_of(d)) return 32'h0;
        return refm[d][bank_of(d, a)][word_of(a)];
    endfunction

    function automatic int exp_lat(int d, logic [31:0] a, bit w);
        if (bank_of(d, a) >= nb_of(d)) return 1;
        return w ? 2 : 2 + rl_of(d);
    endfunction

    function automatic logic [31:0] rand_addr(int d);
        logic [31:0] a;
        int sh;
        sh = 10 + bsw_of(d);
        a = 32'h3000_0000;
        a = a | ($urandom_range(0, (1 << (16 - sh)) - 1) << sh);
        a = a | ($urandom_range(0, nb_of(d) - 1) << 10);
        a = a | ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
        return a;
    endfunction

    // One classic transfer; lat is the cycle ack was seen in (-1 on timeout).
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic [31:0] rd, output int lat,
                        output logic [3:0] csb1, output logic [3:0] web1, output logic [3:0] act1,
                        output logic [3:0] wmask1, output logic [7:0] addr1, output bit low_seen);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dati[d] = wd; sel[d] = s;
        lat = -1; low_seen = 1'b0; rd = 32'h0;
        csb1 = '1; web1 = '1; act1 = '0; wmask1 = '0; addr1 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                csb1 = csb[d]; web1 = web[d]; act1 = act[d]; wmask1 = wmask[d]; addr1 = addr[d];
            end
            if (csb[d] != 4'hF) low_seen = 1'b1;
            if (ack[d]) begin
                lat = c;
                rd  = dato[d];
                break;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 4'hF; cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; dati = '0;
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < 4; k++)
                for (int w = 0; w < 256; w++) refm[d][k][w] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            total++; if ({ack[d], busy[d]} !== 2'b00) begin bad++; $display("FAIL reset_ack_busy[%0d]: got %b want 00", d, {ack[d], busy[d]}); end
            total++; if (dato[d] !== 32'h0) begin bad++; $display("FAIL reset_dat[%0d]: got %h want 0", d, dato[d]); end
            total++; if ({csb[d], web[d]} !== 8'hFF) begin bad++; $display("FAIL reset_csb_web[%0d]: got %h want ff", d, {csb[d], web[d]}); end
            total++; if ({wmask[d], addr[d], din[d], act[d]} !== 48'h0) begin bad++; $display("FAIL reset_sram[%0d]: got %h want 0", d, {wmask[d], addr[d], din[d], act[d]}); end
        end
        rst = '0;
    endtask

    task automatic test_defaults();
        logic [31:0] rd; int lat; logic [3:0] c1, w1, a1, m1; logic [7:0] ad1; bit lo;
        xfer(0, 1'b1, 32'h3000_0004, 32'hDEADBEEF, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        ref_write(0, 32'h3000_0004, 32'hDEADBEEF, 4'hF);
        total++; if (c1 !== 4'b1110) begin bad++; $display("FAIL def_wr_csb: got %b want 1110", c1); end
        total++; if (w1 !== 4'b1110) begin bad++; $display("FAIL def_wr_web: got %b want 1110", w1); end
        total++; if (ad1 !== 8'h01) begin bad++; $display("FAIL def_wr_addr: got %h want 01", ad1); end
        total++; if (lat != 2) begin bad++; $display("FAIL def_wr_lat: got %0d want 2", lat); end
        xfer(0, 1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        total++; if ({c1, w1} !== 8'hEF) begin bad++; $display("FAIL def_rd_csb_web: got %h want ef", {c1, w1}); end
        total++; if (lat != 3) begin bad++; $display("FAIL def_rd_lat: got %0d want 3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL def_rd_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_lane();
        logic [31:0] rd; int lat; logic [3:0] c1, w1, a1, m1; logic [7:0] ad1; bit lo;
        xfer(0, 1'b1, 32'h3000_0008, 32'hAAAAAAAA, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        ref_write(0, 32'h3000_0008, 32'hAAAAAAAA, 4'hF);
        xfer(0, 1'b1, 32'h3000_0008, 32'h11223344, 4'b0100, rd, lat, c1, w1, a1, m1, ad1, lo);
        ref_write(0, 32'h3000_0008, 32'h11223344, 4'b0100);
        total++; if (m1 !== 4'b0100) begin bad++; $display("FAIL bl_wmask: got %b want 0100", m1); end
        xfer(0, 1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        total++; if (rd !== 32'hAA22AAAA) begin bad++; $display("FAIL bl_read: got %h want aa22aaaa", rd); end
        // A write with no lanes still selects the macro and is acknowledged.
        xfer(0, 1'b1, 32'h3000_0008, 32'hFFFFFFFF, 4'h0, rd, lat, c1, w1, a1, m1, ad1, lo);
        ref_write(0, 32'h3000_0008, 32'hFFFFFFFF, 4'h0);
        total++; if ({lat == 2, c1, m1} !== 9'b1_1110_0000) begin bad++; $display("FAIL bl_sel0: got lat=%0d csb=%b wmask=%b want 2/1110/0000", lat, c1, m1); end
        xfer(0, 1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        total++; if (rd !== ref_read(0, 32'h3000_0008)) begin bad++; $display("FAIL bl_sel0_read: got %h want %h", rd, ref_read(0, 32'h3000_0008)); end
    endtask

    task automatic test_bank_boundary();
        logic [31:0] rd; int lat; logic [3:0] c1, w1, a1, m1; logic [7:0] ad1; bit lo;
        xfer(0, 1'b1, 32'h3000_03FC, 32'h0BAD_F00D, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        ref_write(0, 32'h3000_03FC, 32'h0BAD_F00D, 4'hF);
        total++; if ({a1, ad1} !== 12'h1FF) begin bad++; $display("FAIL bb_lo_act_addr: got %h want 1ff", {a1, ad1}); end
        xfer(0, 1'b1, 32'h3000_0400, 32'h1234_5678, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        ref_write(0, 32'h3000_0400, 32'h1234_5678, 4'hF);
        total++; if ({a1, ad1} !== 12'h200) begin bad++; $display("FAIL bb_hi_act_addr: got %h want 200", {a1, ad1}); end
        xfer(0, 1'b0, 32'h3000_03FC, 32'h0, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        total++; if (rd !== 32'h0BAD_F00D) begin bad++; $display("FAIL bb_lo_read: got %h want 0badf00d", rd); end
        xfer(0, 1'b0, 32'h3000_0400, 32'h0, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL bb_hi_read: got %h want 12345678", rd); end
    endtask

    task automatic test_miss();
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h3001_0000;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            total++; if ({ack[0], csb[0], busy[0]} !== 6'b0_1111_0) begin bad++; $display("FAIL miss_c%0d: got ack/csb/busy=%b want 0_1111_0", c, {ack[0], csb[0], busy[0]}); end
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
    endtask

    task automatic test_hole();
        logic [31:0] rd; int lat; logic [3:0] c1, w1, a1, m1; logic [7:0] ad1; bit lo;
        xfer(1, 1'b1, 32'h3000_0800, 32'h7777_7777, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        ref_write(1, 32'h3000_0800, 32'h7777_7777, 4'hF);
        xfer(1, 1'b0, 32'h3000_0800, 32'h0, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        total++; if (rd !== 32'h7777_7777) begin bad++; $display("FAIL hole_pre_read: got %h want 77777777", rd); end
        xfer(1, 1'b1, 32'h3000_0C04, 32'h5A5A_5A5A, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        total++; if ({lat == 1, lo, a1} !== 6'b1_0_0000) begin bad++; $display("FAIL hole_wr: got lat=%0d csb_low=%b act=%b want 1/0/0000", lat, lo, a1); end
        total++; if (rd !== 32'h7777_7777) begin bad++; $display("FAIL hole_wr_keeps_dat: got %h want 77777777", rd); end
        xfer(1, 1'b0, 32'h3000_0C00, 32'h0, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        total++; if ({lat == 1, lo, a1} !== 6'b1_0_0000) begin bad++; $display("FAIL hole_rd: got lat=%0d csb_low=%b act=%b want 1/0/0000", lat, lo, a1); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL hole_rd_data: got %h want 0", rd); end
    endtask

    task automatic test_random(input int d, input int n);
        logic [31:0] rd, a, data; logic [3:0] s; int lat; bit w;
        logic [3:0] c1, w1, a1, m1; logic [7:0] ad1; bit lo;
        for (int i = 0; i < n; i++) begin
            a = rand_addr(d); w = bit'($urandom_range(0, 1)); data = $urandom; s = 4'($urandom_range(0, 15));
            xfer(d, w, a, data, s, rd, lat, c1, w1, a1, m1, ad1, lo);
            total++; if (lat != exp_lat(d, a, w)) begin bad++; $display("FAIL rnd_lat[%0d] a=%h: got %0d want %0d", d, a, lat, exp_lat(d, a, w)); end
            if (w) ref_write(d, a, data, s);
            else begin
                total++; if (rd !== ref_read(d, a)) begin bad++; $display("FAIL rnd_read[%0d] a=%h: got %h want %h", d, a, rd, ref_read(d, a)); end
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat; logic [3:0] c1, w1, a1, m1; logic [7:0] ad1; bit lo;
        xfer(2, 1'b1, 32'h3000_0410, 32'hC0FF_EE11, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        ref_write(2, 32'h3000_0410, 32'hC0FF_EE11, 4'hF);
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 32'h3000_0410;
        repeat (2) @(negedge clk);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(negedge clk);
        total++; if ({ack[2], busy[2], act[2], csb[2]} !== 10'b0_0_0000_1111) begin bad++; $display("FAIL abort_next: got ack/busy/act/csb=%b want 0_0_0000_1111", {ack[2], busy[2], act[2], csb[2]}); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (ack[2] !== 1'b0) begin bad++; $display("FAIL abort_noack_c%0d: got %b want 0", c, ack[2]); end
        end
        xfer(2, 1'b0, 32'h3000_0410, 32'h0, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        total++; if ({lat == 5, rd} !== {1'b1, 32'hC0FF_EE11}) begin bad++; $display("FAIL abort_recover: got lat=%0d data=%h want 5/c0ffee11", lat, rd); end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] rd; int lat; logic [3:0] c1, w1, a1, m1; logic [7:0] ad1; bit lo;
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 32'h3000_0410; dati[2] = 32'h5555_AAAA;
        repeat (2) @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        total++; if ({ack[2], busy[2]} !== 2'b00) begin bad++; $display("FAIL rstw_ack_busy: got %b want 00", {ack[2], busy[2]}); end
        total++; if (dato[2] !== 32'h0) begin bad++; $display("FAIL rstw_dat: got %h want 0", dato[2]); end
        total++; if ({csb[2], web[2]} !== 8'hFF) begin bad++; $display("FAIL rstw_csb_web: got %h want ff", {csb[2], web[2]}); end
        total++; if ({wmask[2], addr[2], din[2], act[2]} !== 48'h0) begin bad++; $display("FAIL rstw_sram: got %h want 0", {wmask[2], addr[2], din[2], act[2]}); end
        rst[2] = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0; dati[2] = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++; if (ack[2] !== 1'b0) begin bad++; $display("FAIL rstw_noack_c%0d: got %b want 0", c, ack[2]); end
        end
        xfer(2, 1'b0, 32'h3000_0410, 32'h0, 4'hF, rd, lat, c1, w1, a1, m1, ad1, lo);
        total++; if (rd !== ref_read(2, 32'h3000_0410)) begin bad++; $display("FAIL rstw_after_read: got %h want %h", rd, ref_read(2, 32'h3000_0410)); end
    endtask

    // stb held across four reads; each ack lands 2+RL cycles after its
    // request edge and the next request edge follows one idle cycle later.
    task automatic test_back_to_back(input int d);
        logic [31:0] addrs [4];
        int idx, acks, rl, exp_c;
        rl = rl_of(d);
        for (int i = 0; i < 4; i++) addrs[i] = rand_addr(d);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = addrs[0];
        idx = 0; acks = 0;
        for (int c = 1; c <= 4 * (3 + rl) + 4; c++) begin
            @(negedge clk);
            if (ack[d]) begin
                acks++;
                if (idx < 4) begin
                    exp_c = (2 + rl) + idx * (3 + rl);
                    total++; if (c != exp_c) begin bad++; $display("FAIL b2b_cycle[%0d] #%0d: got %0d want %0d", d, idx, c, exp_c); end
                    total++; if (dato[d] !== ref_read(d, addrs[idx])) begin bad++; $display("FAIL b2b_data[%0d] #%0d: got %h want %h", d, idx, dato[d], ref_read(d, addrs[idx])); end
                    idx++;
                    if (idx < 4) adr[d] = addrs[idx];
                    else begin cyc[d] = 1'b0; stb[d] = 1'b0; end
                end
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        total++; if (acks != 4) begin bad++; $display("FAIL b2b_ack_count[%0d]: got %0d want 4", d, acks); end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_byte_lane();
        test_bank_boundary();
        test_miss();
        test_hole();
        for (int d = 0; d < 4; d++) test_random(d, 30);
        test_abort();
        test_reset_inflight();
        for (int d = 0; d < 4; d++) test_back_to_back(d);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
